mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core_mem_pkg.sv | 25 ++
 rtl/rr_pick2.sv | 29 ++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// core_mem_pkg -- shared types and constants for the memory arbiter slice.
//   state_e      : arbiter FSM states (idle, memory access in flight, response)
//   gnt_e        : which requester owns the current access (fetch or data)
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   TIMEOUT_FILL : read-data pattern returned when memory never answers;
//                  sliced to the data width at the point of use (up to 64 bits)
package core_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [63:0] TIMEOUT_FILL = {64{1'b1}};

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2 -- combinational two-way round-robin chooser.
//   req_i      : fetch request pending
//   req_d      : data request pending
//   last_grant : owner of the most recent grant
//   grant      : chosen owner (meaningful only when a request is pending)
module rr_pick2
    import core_mem_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  gnt_e last_grant,
    output gnt_e grant
);

    // On contention the side not served last wins; otherwise the sole requester.
    always_comb begin
        grant = last_grant;
        if (req_i && req_d) begin
            grant = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (req_i) begin
            grant = GNT_I;
        end else if (req_d) begin
            grant = GNT_D;
        end else begin
            grant = last_grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one memory port between an instruction-fetch reader
// and a data read/write port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_req/i_addr      : fetch request; i_ack pulses with i_rdata
//   d_req/d_we/d_addr/d_wdata : data request; d_ack pulses with d_rdata
//   mem_req/mem_we/mem_addr/mem_wdata : shared memory request, held through BUSY
//   mem_ready/mem_rdata : memory completion strobe and read data
//   err               : sticky flag, set when memory fails to answer in TIMEOUT cycles
// One access is in flight at a time: IDLE -> BUSY -> RESP -> IDLE, so at most one
// access per three cycles. All outputs come straight from flops.
module mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    // Counter spans 0 .. TIMEOUT-1; its last value marks the final BUSY cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] FILL = TIMEOUT_FILL[DATA_W-1:0];

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    gnt_e              last_grant_q, last_grant_d;
    gnt_e              pick_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] resp_data_s;

    rr_pick2 u_pick (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant_q),
        .grant      (pick_s)
    );

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;
        resp_data_s  = {DATA_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_d      = ST_BUSY;
                    gnt_d        = pick_s;
                    last_grant_d = pick_s;
                    cnt_d        = {CNT_W{1'b0}};
                    mem_req_d    = 1'b1;
                    if (pick_s == GNT_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A ready strobe in the final counted cycle still completes normally.
                if (mem_ready || (cnt_q == CNT_LAST)) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {ADDR_W{1'b0}};
                    mem_wdata_d = {DATA_W{1'b0}};
                    if (mem_ready) begin
                        resp_data_s = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
                    end else begin
                        resp_data_s = FILL;
                        err_d       = 1'b1;
                    end
                    if (gnt_q == GNT_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = resp_data_s;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = resp_data_s;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= GNT_I;
            last_grant_q <= GNT_D;
            cnt_q        <= {CNT_W{1'b0}};
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= {DATA_W{1'b0}};
            d_rdata_q    <= {DATA_W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter (TIMEOUT = 8).
// A small memory model asserts mem_ready after a programmable number of wait
// cycles; inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'h0000;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata = 16'h0000;
    logic        err;

    logic        mem_en = 1'b1;
    int          mem_wait = 0;
    int          busy_cnt = 0;

    int          n_checks = 0;
    int          n_errors = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory model: counts cycles the request has been up, answers after mem_wait.
    always @(posedge clk) begin
        if (mem_req) busy_cnt <= busy_cnt + 1;
        else         busy_cnt <= 0;
    end
    assign mem_ready = mem_en && mem_req && (busy_cnt >= mem_wait);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_i_ack",   {31'd0, i_ack},   32'd0);
        check_eq("rst_d_ack",   {31'd0, d_ack},   32'd0);
        check_eq("rst_err",     {31'd0, err},     32'd0);
        check_eq("rst_i_rdata", {16'd0, i_rdata}, 32'd0);
        rst_n = 1'b1;

        // Zero-wait fetch: granted at the first edge after reset release
        mem_wait = 0; mem_rdata = 16'h1234;
        i_req = 1'b1; i_addr = 16'h0004;
        @(negedge clk);
        check_eq("f_mem_req",  {31'd0, mem_req},   32'd1);
        check_eq("f_mem_addr", {16'd0, mem_addr},  32'h0004);
        check_eq("f_mem_we",   {31'd0, mem_we},    32'd0);
        check_eq("f_mem_wd",   {16'd0, mem_wdata}, 32'd0);
        check_eq("f_early_ack", {31'd0, i_ack},    32'd0);
        @(negedge clk);
        check_eq("f_i_ack",    {31'd0, i_ack},     32'd1);
        check_eq("f_i_rdata",  {16'd0, i_rdata},   32'h1234);
        check_eq("f_d_ack",    {31'd0, d_ack},     32'd0);
        check_eq("f_req_drop", {31'd0, mem_req},   32'd0);
        i_req = 1'b0;
        @(negedge clk);
        check_eq("f_ack_end",  {31'd0, i_ack},     32'd0);
        check_eq("f_rd_hold",  {16'd0, i_rdata},   32'h1234);

        // Data write with three memory wait cycles
        mem_wait = 3; mem_rdata = 16'h5555;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("w_mem_req",  {31'd0, mem_req},   32'd1);
            check_eq("w_mem_we",   {31'd0, mem_we},    32'd1);
            check_eq("w_mem_addr", {16'd0, mem_addr},  32'h0010);
            check_eq("w_mem_wd",   {16'd0, mem_wdata}, 32'hBEEF);
            check_eq("w_no_ack",   {31'd0, d_ack},     32'd0);
        end
        @(negedge clk);
        check_eq("w_req_drop", {31'd0, mem_req}, 32'd0);
        check_eq("w_d_ack",    {31'd0, d_ack},   32'd1);
        check_eq("w_d_rdata",  {16'd0, d_rdata}, 32'd0);
        check_eq("w_i_ack",    {31'd0, i_ack},   32'd0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check_eq("w_ack_end",  {31'd0, d_ack},   32'd0);

        // Contended round-robin from a fresh reset: I, D, I, D
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_wait = 0; mem_rdata = 16'h00AA;
        i_req = 1'b1; i_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            case (j % 3)
                0: begin
                    check_eq("rr_mem_req", {31'd0, mem_req}, 32'd1);
                    check_eq("rr_addr", {16'd0, mem_addr},
                             (((j / 3) % 2) == 0) ? 32'h0020 : 32'h0030);
                    check_eq("rr_busy_acks", {30'd0, i_ack, d_ack}, 32'd0);
                end
                1: begin
                    check_eq("rr_acks", {30'd0, i_ack, d_ack},
                             (((j / 3) % 2) == 0) ? 32'd2 : 32'd1);
                    check_eq("rr_rdata", {16'd0, ((((j / 3) % 2) == 0) ? i_rdata : d_rdata)},
                             32'h00AA);
                    check_eq("rr_resp_req", {31'd0, mem_req}, 32'd0);
                end
                default: begin
                    check_eq("rr_idle_acks", {30'd0, i_ack, d_ack}, 32'd0);
                    check_eq("rr_idle_req", {31'd0, mem_req}, 32'd0);
                end
            endcase
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Ready in the very last counted cycle: normal completion, no error
        mem_wait = 7; mem_rdata = 16'h0BAD;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0044;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("edge_busy", {31'd0, mem_req}, 32'd1);
        end
        @(negedge clk);
        check_eq("edge_d_ack",   {31'd0, d_ack},   32'd1);
        check_eq("edge_d_rdata", {16'd0, d_rdata}, 32'h0BAD);
        check_eq("edge_err",     {31'd0, err},     32'd0);
        d_req = 1'b0;
        @(negedge clk);

        // Timeout: memory never answers
        mem_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("to_busy",   {31'd0, mem_req}, 32'd1);
            check_eq("to_no_ack", {31'd0, d_ack},   32'd0);
            check_eq("to_no_err", {31'd0, err},     32'd0);
        end
        @(negedge clk);
        check_eq("to_d_ack",   {31'd0, d_ack},   32'd1);
        check_eq("to_d_rdata", {16'd0, d_rdata}, 32'hFFFF);
        check_eq("to_err",     {31'd0, err},     32'd1);
        d_req = 1'b0;
        @(negedge clk);
        mem_en = 1'b1; mem_wait = 0; mem_rdata = 16'h7777;
        i_req = 1'b1; i_addr = 16'h0050;
        @(negedge clk);
        @(negedge clk);
        check_eq("to_next_ack", {31'd0, i_ack},   32'd1);
        check_eq("to_next_rd",  {16'd0, i_rdata}, 32'h7777);
        check_eq("to_err_held", {31'd0, err},     32'd1);
        i_req = 1'b0;
        @(negedge clk);

        // Reset in the second BUSY cycle abandons the access
        mem_en = 1'b0;
        i_req = 1'b1; i_addr = 16'h0058;
        @(negedge clk);
        check_eq("ra_busy1", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        check_eq("ra_busy2", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        check_eq("ra_req_drop", {31'd0, mem_req}, 32'd0);
        check_eq("ra_err_clr",  {31'd0, err},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("ra_no_ack", {30'd0, i_ack, d_ack}, 32'd0);
        end
        mem_en = 1'b1; mem_wait = 0; mem_rdata = 16'h0C0C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
        @(negedge clk);
        check_eq("ra_next_addr", {16'd0, mem_addr}, 32'h0060);
        @(negedge clk);
        check_eq("ra_next_ack", {31'd0, d_ack},   32'd1);
        check_eq("ra_next_rd",  {16'd0, d_rdata}, 32'h0C0C);
        check_eq("ra_next_err", {31'd0, err},     32'd0);
        d_req = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
